// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue
//   Beat FIFO between the AXI instruction-fetch FSM and decode. Each 64-bit
//   read beat is stored with its fetch PC and then handed to decode as two
//   32-bit instructions, lower word first. A beat entered at PC[2]=1 yields
//   only its upper word.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   flush             drop all buffered beats and the pending half-select
//   in_valid/in_ready beat handshake from the fetch FSM
//   in_data           beat: [31:0] at PC, [63:32] at PC+4
//   in_pc             beat PC (bits [1:0] ignored)
//   in_last           beat ends its burst
//   out_valid/out_ready instruction handshake to decode
//   out_inst, out_pc  current instruction and its PC
//   out_last          out_inst is the upper word of a last beat
//   out_zero          out_inst is all zeros (gated by out_valid)
//   inst_count        instructions delivered since reset (wraps)
module fetch_inst_queue #(
  parameter int DEPTH    = 8,
  parameter int PC_WIDTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [63:0]         in_data,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_inst,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic                out_last,
  output logic                out_zero,
  output logic [31:0]         inst_count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [63:0]         mem_data       [DEPTH];
  logic [PC_WIDTH-4:0] mem_pc         [DEPTH];
  logic                mem_start_half [DEPTH];
  logic                mem_last       [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   count;
  logic          half;

  logic          push;
  logic          pop;
  logic          pop_beat;
  logic [63:0]   head_data;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^in_pc[1:0];

  // No bypass: a full queue refuses a beat even while decode is popping.
  assign in_ready  = (count != FULL_CNT) && !flush;
  assign out_valid = (count != '0);

  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready && !flush;
  assign pop_beat   = pop && half;
  assign rd_ptr_nxt = rd_ptr + 1'b1;

  assign head_data = mem_data[rd_ptr];
  assign out_inst  = half ? head_data[63:32] : head_data[31:0];
  assign out_pc    = {mem_pc[rd_ptr], half, 2'b00};
  assign out_last  = out_valid && half && mem_last[rd_ptr];
  // Gated so that unwritten storage can never raise the terminate hint.
  assign out_zero  = out_valid && (out_inst == 32'h0);

  // Beat storage: data path only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]       <= in_data;
      mem_pc[wr_ptr]         <= in_pc[PC_WIDTH-1:3];
      mem_start_half[wr_ptr] <= in_pc[2];
      mem_last[wr_ptr]       <= in_last;
    end
  end

  // Pointer / occupancy / half-select control.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      half   <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (pop_beat) rd_ptr <= rd_ptr_nxt;

      case ({push, pop_beat})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Whenever a new entry becomes head, half takes its start_half. When the
      // last buffered beat retires in the same cycle a beat arrives, the new
      // head is the incoming beat, whose start_half is still on in_pc.
      if (pop_beat) begin
        if (count == ONE_CNT) half <= push ? in_pc[2] : 1'b0;
        else                  half <= mem_start_half[rd_ptr_nxt];
      end else if (pop) begin
        half <= 1'b1;
      end else if (push && (count == '0)) begin
        half <= in_pc[2];
      end
    end
  end

  // Delivered-instruction counter survives flush, clears on reset.
  always_ff @(posedge clk) begin
    if (reset)    inst_count <= '0;
    else if (pop) inst_count <= inst_count + 32'd1;
  end

endmodule

// File: doc/fetch_inst_queue.md
Name: fetch_inst_queue

Overview:
- Sits directly downstream of the AXI instruction-fetch FSM and upstream of decode.
- Accepts 64-bit read-data beats, each tagged with the fetch PC, and stores them in a small beat FIFO.
- Splits each beat into two 32-bit instructions and presents them one at a time to decode with their PCs, using a valid/ready handshake.
- Supports flush on redirect, unaligned entry PCs (PC[2]=1), and a delivered-instruction counter.

Parameters:
- DEPTH, 8, number of 64-bit beat entries (power of 2, >=2); one 8-beat burst by default.
- PC_WIDTH, 64, width of program counter fields.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all buffered beats and the pending half-select.
- in_valid  input  1  beat available from fetch FSM.
- in_ready  output  1  queue can accept a beat this cycle.
- in_data  input  64  beat; [31:0] = instruction at PC, [63:32] = instruction at PC+4.
- in_pc  input  PC_WIDTH  PC of the beat; bits [1:0] ignored.
- in_last  input  1  beat is last of its burst (mirrors rlast).
- out_valid  output  1  instruction available to decode.
- out_ready  input  1  decode accepts instruction.
- out_inst  output  32  current instruction.
- out_pc  output  PC_WIDTH  PC of out_inst = {entry_pc[PC_WIDTH-1:3], half, 2'b00}.
- out_last  output  1  out_inst is the upper half of an in_last beat.
- out_zero  output  1  out_inst == 32'h0 (terminate hint to the core).
- inst_count  output  32  number of instructions handed to decode since reset; wraps modulo 2^32.

Behaviour:
- Storage per entry: data[63:0], pc[PC_WIDTH-1:3], start_half (= in_pc[2]), last.
- Pointers: wr_ptr, rd_ptr (log2(DEPTH) bits, wrap naturally); count (log2(DEPTH)+1 bits); half (1 bit, selects the word within the rd_ptr entry).
- in_ready = (count != DEPTH) && !flush. It is combinational and does not depend on out_ready, so there is no bypass when full.
- Push: occurs when in_valid && in_ready. The entry is written at the clock edge. The earliest out_valid is the next cycle (1-cycle latency).
- out_valid = (count != 0). Outputs are combinational from the rd_ptr entry and half.
- out_inst = half ? data[63:32] : data[31:0]. out_last = last && half. out_zero = (out_inst == 0).
- Pop handshake: out_valid && out_ready.
  - If half==0: half <= 1.
  - If half==1: rd_ptr++, count--. half loads the start_half of the next entry (0 if the queue becomes empty; reloaded on the next push).
- half rule: whenever a new entry becomes head (push into empty queue, or pop advancing rd_ptr), half <= that entry's start_half. An entry pushed with in_pc[2]=1 therefore delivers only its upper word; the lower word is never presented.
- Simultaneous push and final-half pop in one cycle: count is unchanged, both pointers advance, half loads the start_half of the new head.
- inst_count increments by 1 on every pop handshake.
- Flush (synchronous, priority over push and pop):
  - Next cycle: count=0, wr_ptr=rd_ptr=0, half=0.
  - Any push or pop in the flush cycle is discarded and inst_count is not incremented.
  - inst_count is not cleared by flush.
- Reset values: count=0, pointers=0, half=0, inst_count=0. Hence out_valid=0, in_ready=1, out_last=0.
  - out_inst and out_pc are don't-care while out_valid=0, but memory reads must not produce X-propagation into out_zero. Gate out_zero with out_valid, so it is 0 at reset.
- Reset mid-operation: all contents are dropped exactly as for flush, and inst_count clears.
- No state machine beyond the pointer/half logic. Backpressure from decode must never drop or duplicate an instruction.

Test Plan:
- Reset, then push in_data=64'h00000013_00100093 at in_pc=0x1000, out_ready=1 -> cycle+1: out_inst=0x00100093, out_pc=0x1000. Cycle+2: out_inst=0x00000013, out_pc=0x1004. Then out_valid=0, inst_count=2.
- Push 8 beats (in_last on the 8th) with out_ready=0 -> in_ready drops to 0 after the 8th. Then release out_ready -> 16 instructions, PCs 0x2000..0x203C in order. out_last=1 only on PC 0x203C.
- Push in_pc=0x3004, in_data=64'hAAAAAAAA_BBBBBBBB -> only out_inst=0xAAAAAAAA with out_pc=0x3004 is delivered. inst_count +1.
- Queue full (8 entries), out_ready=1 and in_valid=1 held -> exactly one push per full-beat pop, no loss or duplication. Check ordering over 32 beats.
- Four beats queued, mid-beat (half=1), assert flush with in_valid=1 -> next cycle out_valid=0, count=0, the in-flight beat is dropped, inst_count unchanged.
- Push in_data=64'h0 -> out_zero=1 on both halves. out_zero=0 when out_valid=0. Assert reset with entries present -> out_valid=0 and inst_count=0 next cycle.
